// File: rtl/alarm_time_entry_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alarm_time_entry_pkg
//  Purpose  : Shared types and constants for the alarm time-entry controller.
//  Revision : 1.0 - initial release
// ============================================================================
package alarm_time_entry_pkg;

    typedef enum logic [1:0] {
        ST_EDIT = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    typedef logic [3:0] bcd_t;

    localparam logic [1:0] CUR_H_MSB = 2'd0;
    localparam logic [1:0] CUR_H_LSB = 2'd1;
    localparam logic [1:0] CUR_M_MSB = 2'd2;
    localparam logic [1:0] CUR_M_LSB = 2'd3;

    localparam bcd_t MIN_MSB_MAX = 4'd5;
    localparam bcd_t DIGIT_MAX   = 4'd9;

    // Increment with wrap to zero once the digit reaches its limit.
    function automatic bcd_t bcd_wrap_inc(input bcd_t d, input bcd_t lim);
        return (d >= lim) ? 4'd0 : d + 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_time_entry_button_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : button_debouncer
//  Purpose  : Synchronizer, debounce filter and rising-edge press pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [1:0]    fill_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          level_prev_q;
    logic          arm_q;
    logic          press_q;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = sync_q[1];
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // A press is only honoured once the button has been seen released after
    // reset, so a button held through reset must be let go first.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q       <= 2'b00;
            fill_q       <= 2'b00;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            arm_q        <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], btn_i};
            fill_q       <= {fill_q[0], 1'b1};
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            if (fill_q[1] && !sync_q[1]) begin
                arm_q <= 1'b1;
            end
            press_q      <= level_q & ~level_prev_q & arm_q;
        end
    end

    assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/alarm_time_entry.sv
`default_nettype none
// ============================================================================
//  Module   : alarm_time_entry
//  Purpose  : Button-driven BCD HH:MM entry with range checks and load strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module alarm_time_entry
    import alarm_time_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int LOAD_PULSE_CYCLES = 4,
    parameter int HOUR_MAX          = 23
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_next,
    input  logic       btn_inc,
    input  logic       btn_start,
    output logic [3:0] h_msb,
    output logic [3:0] h_lsb,
    output logic [3:0] m_msb,
    output logic [3:0] m_lsb,
    output logic       alarm_enable,
    output logic [1:0] cursor,
    output logic       editing,
    output logic       reject
);

    localparam bcd_t       HOUR_T     = bcd_t'(HOUR_MAX / 10);
    localparam bcd_t       HOUR_U     = bcd_t'(HOUR_MAX % 10);
    localparam logic [3:0] PULSE_LAST = 4'(LOAD_PULSE_CYCLES - 1);

    logic [2:0] w_btn;
    logic [2:0] w_press;

    state_e     state_q, state_d;
    bcd_t       h_msb_q, h_msb_d, h_lsb_q, h_lsb_d;
    bcd_t       m_msb_q, m_msb_d, m_lsb_q, m_lsb_d;
    logic [1:0] cursor_q, cursor_d;
    logic [3:0] pulse_q, pulse_d;
    logic       alarm_q, alarm_d;
    logic       reject_q, reject_d;
    bcd_t       w_hm_inc;

    assign w_btn = {btn_start, btn_inc, btn_next};

    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .reset  (reset),
            .btn_i  (w_btn[gi]),
            .press_o(w_press[gi])
        );
    end

    assign w_hm_inc = bcd_wrap_inc(h_msb_q, HOUR_T);

    always_comb begin
        state_d  = state_q;
        h_msb_d  = h_msb_q;
        h_lsb_d  = h_lsb_q;
        m_msb_d  = m_msb_q;
        m_lsb_d  = m_lsb_q;
        cursor_d = cursor_q;
        pulse_d  = pulse_q;
        alarm_d  = 1'b1;
        reject_d = 1'b0;
        case (state_q)
            ST_EDIT: begin
                if (w_press[2]) begin
                    if ({h_msb_q, h_lsb_q, m_msb_q, m_lsb_q} == 16'h0000) begin
                        reject_d = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                        alarm_d = 1'b0;
                        pulse_d = PULSE_LAST;
                    end
                end else if (w_press[0]) begin
                    cursor_d = cursor_q + 2'd1;
                end else if (w_press[1]) begin
                    case (cursor_q)
                        CUR_H_MSB: begin
                            h_msb_d = w_hm_inc;
                            // Moving into the top tens value may make the units illegal.
                            if (w_hm_inc == HOUR_T && h_lsb_q > HOUR_U) begin
                                h_lsb_d = HOUR_U;
                            end
                        end
                        CUR_H_LSB: h_lsb_d = bcd_wrap_inc(h_lsb_q,
                                        (h_msb_q == HOUR_T) ? HOUR_U : DIGIT_MAX);
                        CUR_M_MSB: m_msb_d = bcd_wrap_inc(m_msb_q, MIN_MSB_MAX);
                        default:   m_lsb_d = bcd_wrap_inc(m_lsb_q, DIGIT_MAX);
                    endcase
                end
            end
            ST_LOAD: begin
                if (pulse_q == 4'd0) begin
                    state_d = ST_RUN;
                end else begin
                    alarm_d = 1'b0;
                    pulse_d = pulse_q - 4'd1;
                end
            end
            ST_RUN: begin
                if (w_press[2]) begin
                    state_d = ST_EDIT;
                end
            end
            default: state_d = ST_EDIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_EDIT;
            h_msb_q  <= 4'd0;
            h_lsb_q  <= 4'd0;
            m_msb_q  <= 4'd0;
            m_lsb_q  <= 4'd0;
            cursor_q <= 2'd0;
            pulse_q  <= 4'd0;
            alarm_q  <= 1'b1;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            h_msb_q  <= h_msb_d;
            h_lsb_q  <= h_lsb_d;
            m_msb_q  <= m_msb_d;
            m_lsb_q  <= m_lsb_d;
            cursor_q <= cursor_d;
            pulse_q  <= pulse_d;
            alarm_q  <= alarm_d;
            reject_q <= reject_d;
        end
    end

    assign h_msb        = h_msb_q;
    assign h_lsb        = h_lsb_q;
    assign m_msb        = m_msb_q;
    assign m_lsb        = m_lsb_q;
    assign cursor       = cursor_q;
    assign alarm_enable = alarm_q;
    assign reject       = reject_q;
    assign editing      = (state_q == ST_EDIT);

endmodule
`default_nettype wire

// File: tb/tb_alarm_time_entry.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alarm_time_entry
//  Purpose  : Scoreboard bench for the alarm time-entry controller.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alarm_time_entry;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_next, btn_inc, btn_start;
    logic [3:0] h_msb, h_lsb, m_msb, m_lsb;
    logic       alarm_enable, editing, reject;
    logic [1:0] cursor;

    always #5 clk = ~clk;

    alarm_time_entry #(
        .DEBOUNCE_CYCLES  (4),
        .LOAD_PULSE_CYCLES(4),
        .HOUR_MAX         (23)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_next    (btn_next),
        .btn_inc     (btn_inc),
        .btn_start   (btn_start),
        .h_msb       (h_msb),
        .h_lsb       (h_lsb),
        .m_msb       (m_msb),
        .m_lsb       (m_lsb),
        .alarm_enable(alarm_enable),
        .cursor      (cursor),
        .editing     (editing),
        .reject      (reject)
    );

    typedef struct packed {
        logic [3:0] hm, hl, mm, ml;
        logic [1:0] cur;
        logic       ed;
    } snap_t;

    snap_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [3:0] m_hm, m_hl, m_mm, m_ml;
    logic [1:0] m_cur;
    logic       m_ed;

    // Cumulative monitor counters; tests work with differences
    int low_cnt = 0;
    int low_bad = 0;
    int rej_cnt = 0;

    always @(negedge clk) begin
        if (alarm_enable === 1'b0) begin
            low_cnt++;
            if ({h_msb, h_lsb, m_msb, m_lsb} !== {m_hm, m_hl, m_mm, m_ml}) low_bad++;
        end
        if (reject === 1'b1) rej_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_hm = 0; m_hl = 0; m_mm = 0; m_ml = 0; m_cur = 0; m_ed = 1'b1;
    endtask

    task automatic model_apply(input logic n, input logic i, input logic s);
        if (s) begin
            if (!m_ed) m_ed = 1'b1;
            else if ({m_hm, m_hl, m_mm, m_ml} != 16'h0) m_ed = 1'b0;
        end else if (m_ed && n) begin
            m_cur = m_cur + 2'd1;
        end else if (m_ed && i) begin
            case (m_cur)
                2'd0: begin
                    m_hm = (m_hm == 4'd2) ? 4'd0 : m_hm + 4'd1;
                    if (m_hm == 4'd2 && m_hl > 4'd3) m_hl = 4'd3;
                end
                2'd1: m_hl = (m_hl >= ((m_hm == 4'd2) ? 4'd3 : 4'd9)) ? 4'd0 : m_hl + 4'd1;
                2'd2: m_mm = (m_mm == 4'd5) ? 4'd0 : m_mm + 4'd1;
                default: m_ml = (m_ml == 4'd9) ? 4'd0 : m_ml + 4'd1;
            endcase
        end
    endtask

    task automatic compare_out();
        snap_t e;
        if (exp_q.size() == 0) begin
            check_eq("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_eq("h_msb",   h_msb,   e.hm);
            check_eq("h_lsb",   h_lsb,   e.hl);
            check_eq("m_msb",   m_msb,   e.mm);
            check_eq("m_lsb",   m_lsb,   e.ml);
            check_eq("cursor",  cursor,  e.cur);
            check_eq("editing", editing, e.ed);
        end
    endtask

    task automatic press(input logic n, input logic i, input logic s);
        @(posedge clk); #1;
        btn_next = n; btn_inc = i; btn_start = s;
        model_apply(n, i, s);
        exp_q.push_back('{m_hm, m_hl, m_mm, m_ml, m_cur, m_ed});
        tick(8);
        btn_next = 0; btn_inc = 0; btn_start = 0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        compare_out();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lbase, rbase, bbase;
        bit seen;
        reset = 1'b1; btn_next = 0; btn_inc = 0; btn_start = 0;
        model_reset();
        tick(3);
        reset = 1'b0;

        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            check_eq("idle", {h_msb, h_lsb, m_msb, m_lsb, alarm_enable, cursor, editing, reject},
                     {16'h0000, 1'b1, 2'b00, 1'b1, 1'b0});
        end

        // Bouncing inc: settles as exactly one press
        @(posedge clk); #1;
        btn_inc = 1; tick(1); btn_inc = 0; tick(1);
        btn_inc = 1; tick(1); btn_inc = 0; tick(1);
        btn_inc = 1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check_eq("bounce_before", h_msb, 4'd0);
        @(posedge clk);
        @(negedge clk);
        check_eq("bounce_after", h_msb, 4'd1);
        tick(2);
        btn_inc = 0;
        tick(12);
        check_eq("bounce_single", h_msb, 4'd1);
        model_apply(0, 1, 0);

        // Hour units sweep, then tens increment with clamp
        press(1, 0, 0);
        for (int k = 0; k < 10; k++) press(0, 1, 0);
        for (int k = 0; k < 7; k++) press(0, 1, 0);
        for (int k = 0; k < 3; k++) press(1, 0, 0);
        press(0, 1, 0);
        check_eq("clamp_h_lsb", h_lsb, 4'd3);

        // Commit of 00:00 is refused
        do_reset();
        rbase = rej_cnt; lbase = low_cnt;
        press(0, 0, 1);
        check_eq("reject_cycles", rej_cnt - rbase, 1);
        check_eq("reject_no_load", low_cnt - lbase, 0);

        // Enter 01:30 and commit
        press(1, 0, 0);
        press(0, 1, 0);
        press(1, 0, 0);
        for (int k = 0; k < 3; k++) press(0, 1, 0);
        lbase = low_cnt; bbase = low_bad;
        press(0, 0, 1);
        check_eq("load_low_cycles", low_cnt - lbase, 4);
        check_eq("load_digits_stable", low_bad - bbase, 0);
        press(0, 1, 0);
        press(1, 0, 0);
        press(0, 0, 1);

        // Reset during the second low cycle of the load pulse
        lbase = low_cnt;
        @(posedge clk); #1;
        btn_start = 1;
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (alarm_enable === 1'b0) seen = 1;
        end
        check_eq("load_seen", seen, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1; btn_start = 0;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_mid_load", {alarm_enable, editing, h_msb, h_lsb, m_msb, m_lsb},
                 {1'b1, 1'b1, 16'h0000});
        #1;
        reset = 1'b0;
        model_reset();
        tick(20);
        check_eq("rst_mid_load_lows", low_cnt - lbase, 2);

        // A button held through reset does not register until re-pressed
        btn_inc = 1; tick(3);
        reset = 1'b1; tick(2);
        reset = 1'b0; model_reset();
        tick(20);
        btn_inc = 0;
        tick(12);
        check_eq("held_reset", h_msb, 4'd0);
        press(0, 1, 0);

        // Simultaneous next + inc: only the cursor moves
        press(1, 1, 0);

        check_eq("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alarm_time_entry.md
Name: alarm_time_entry

Overview:
Button-driven time-entry controller that produces the BCD HH:MM value and active-low load strobe consumed by the countdown alarm block. Three raw push-buttons select a digit, increment it and commit it. Entered values are range-checked, and the block sits between the board buttons and the alarm's h_msb/h_lsb/m_msb/m_lsb/alarm_enable inputs.

Parameters:
DEBOUNCE_CYCLES, 500000, cycles a synchronized button must hold a new level before it is accepted (10 ms at 50 MHz).
LOAD_PULSE_CYCLES, 4, number of cycles alarm_enable is held low on commit (range 1..15).
HOUR_MAX, 23, largest enterable hour value (BCD digits limited accordingly).

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
btn_next  in  1  raw asynchronous button, active-high; advance cursor
btn_inc  in  1  raw asynchronous button, active-high; increment digit under cursor
btn_start  in  1  raw asynchronous button, active-high; commit in EDIT, return to EDIT in RUN
h_msb  out  4  hours tens digit, BCD
h_lsb  out  4  hours units digit, BCD
m_msb  out  4  minutes tens digit, BCD
m_lsb  out  4  minutes units digit, BCD
alarm_enable  out  1  idle high; low pulse of LOAD_PULSE_CYCLES loads alarm (falling edge = load)
cursor  out  2  selected digit: 0=h_msb 1=h_lsb 2=m_msb 3=m_lsb
editing  out  1  high in EDIT state
reject  out  1  one-cycle pulse when commit refused

Behaviour:
- Reset values: all digits 0, alarm_enable=1, cursor=0, editing=1, reject=0, FSM=EDIT, debouncers cleared to "released".
- Button path: 2-FF synchronizer -> debounce counter (restarts on any level change; state accepted after DEBOUNCE_CYCLES stable) -> rising-edge detect gives one-cycle press. Press latency from raw edge: 2 + DEBOUNCE_CYCLES + 1 cycles. Release edges produce nothing. Holding does not auto-repeat.
- Priority per cycle: start > next > inc; lower-priority presses in the same cycle are discarded.
- FSM states: EDIT, LOAD, RUN.
- EDIT: next -> cursor+1 mod 4 (3 wraps to 0). inc -> selected digit +1 with wrap:
  - h_msb: 0..HOUR_MAX/10 -> 0.
  - h_lsb: 0..9, or 0..HOUR_MAX%10 when h_msb==HOUR_MAX/10.
  - m_msb: 0..5.
  - m_lsb: 0..9.
- Incrementing h_msb to HOUR_MAX/10 clamps h_lsb to HOUR_MAX%10 if greater, in the same cycle.
- EDIT, start: if all digits 0, pulse reject and stay in EDIT. Otherwise go to LOAD next cycle.
- LOAD: alarm_enable=0 for exactly LOAD_PULSE_CYCLES cycles (counter loaded on entry), then alarm_enable=1 and go to RUN. All presses ignored. Digits are stable for the whole pulse and one cycle after.
- RUN: editing=0. Digits hold their committed values. next/inc are ignored. start -> EDIT with digits and cursor unchanged.
- Outputs are registered; a press visible at cycle N changes outputs at N+1.
- Reset mid-LOAD: alarm_enable returns to 1 at the next edge, and no further low cycles occur.
- Reset while a button is held: that button must be released and pressed again to register.

Decomposition:
- Shared package: FSM state enum (EDIT/LOAD/RUN); cursor index constants; per-digit max constants MIN_MSB_MAX=5, DIGIT_MAX=9; BCD digit type (4-bit).
- Sub-module: button_debouncer (synchronizer + debounce counter + rising-edge pulse, parameter DEBOUNCE_CYCLES), instantiated three times.

Test Plan (DEBOUNCE_CYCLES=4, LOAD_PULSE_CYCLES=4):
- Reset then idle 50 cycles -> digits 0000, alarm_enable=1, cursor=0, editing=1, reject=0 throughout.
- Bounce btn_inc 1-0-1-0-1 at 1-cycle spacing, then hold 10 cycles -> exactly one press; h_msb=1, observed 2+4+1+1 cycles after the final stable edge.
- Cursor 1, 10 inc presses -> h_lsb 1..9 then 0. Set h_msb=1, h_lsb=7; at cursor 0 press inc -> h_msb=2 and h_lsb clamped to 3.
- Press start with 00:00 -> reject high one cycle, state stays EDIT, alarm_enable stays 1.
- Enter 01:30, press start -> alarm_enable low exactly 4 cycles with digits 0,1,3,0 stable, editing=0 afterwards. inc/next in RUN leave digits unchanged. start returns editing=1 with digits preserved.
- Assert reset on the 2nd low cycle of alarm_enable -> alarm_enable=1 next edge, digits 0, editing=1. Simultaneous next+inc in EDIT -> only cursor advances.
